fetch_queue_stage: RTL
======================

# fetch_queue_stage

Parametrised instruction-fetch stage for the pipelined OTTER. It drives a program counter, issues one-cycle-latency reads to instruction memory port 1, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue feeds the IF/ID boundary with a valid/ready handshake. Redirects from JALR/BRANCH/JAL flush both the queue and any in-flight read, so decode stalls never drop or duplicate instructions.

## Interface
- XLEN, 32, datapath and PC width.
- DEPTH, 4, queue entries; power of two, ≥2.
- ADDR_W, 14, memory word-address width; address taken from PC[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, PC loaded on reset.

- CLOCK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- PC_SOURCE  in  2  0 = sequential; 1 = JALR; 2 = BRANCH; 3 = JAL. Any nonzero value is a redirect.
- MUX_JALR, MUX_BRANCH, MUX_JAL  in  XLEN each  redirect targets, selected by PC_SOURCE.
- MEM_ADDR1  out  ADDR_W  word address of the read being issued.
- MEM_RDEN1  out  1  read issue strobe.
- MEM_DOUT1  in  32  read data, valid the cycle after MEM_RDEN1.
- IF_ID_READY  in  1  decode accepts the head entry this cycle.
- IF_ID_VALID  out  1  head entry valid.
- IF_ID_IR  out  32  head instruction; 32'h0000_0013 (NOP) when not valid.
- IF_ID_PC  out  XLEN  head PC; 0 when not valid.
- IF_ID_PC_4  out  XLEN  IF_ID_PC + 4, modulo 2^XLEN; 0 when not valid.

## Operation
- State:
  - pc: next fetch address.
  - inflight: 1 bit, plus inflight_pc.
  - queue of {ir, pc} entries.
  - count: $clog2(DEPTH)+1 bits.
- pop = IF_ID_VALID & IF_ID_READY. IF_ID_VALID = (count != 0).
- Issue condition: no redirect, and count + inflight − pop < DEPTH.
- On issue:
  - MEM_RDEN1 = 1 and MEM_ADDR1 = pc[ADDR_W+1:2].
  - inflight ← 1, inflight_pc ← pc, pc ← pc + 4.
- If inflight is set, MEM_DOUT1 with inflight_pc is pushed at the tail that cycle; inflight is cleared unless a new issue occurs.
- Push and pop may occur in the same cycle; count is unchanged.
- The queue can never overflow: push requires a reserved slot. Push into a full queue is an assertion failure.
- Redirect (PC_SOURCE != 0) has priority over all other activity:
  - pc ← selected target; count ← 0; inflight ← 0 (return data discarded).
  - MEM_RDEN1 = 0 that cycle.
  - A pop in the redirect cycle still completes from decode's view; the queue is cleared regardless.
- PC wraps modulo 2^XLEN. Misalignment of the target is not checked; bits [1:0] pass through to IF_ID_PC.
- Reset values:
  - pc = RESET_PC; count = 0; inflight = 0.
  - IF_ID_VALID = 0, IF_ID_IR = NOP, IF_ID_PC = 0, IF_ID_PC_4 = 0.
  - MEM_RDEN1 = 0 during reset.
- RESET mid-operation discards the queue and any in-flight read, identically to a redirect to RESET_PC.

## Timing
- Issue at cycle t → push at end of t+1 → IF_ID_VALID at t+2. There is no bypass from MEM_DOUT1 to the outputs.
- Redirect at cycle r → first issue at r+1 → IF_ID_VALID at r+3.
- With IF_ID_READY held high, steady-state throughput is one instruction per cycle.
- With IF_ID_READY low, the queue fills to DEPTH, then issue stops (MEM_RDEN1 = 0). Issue restarts in the same cycle as the first pop.
- Outputs IF_ID_* are combinational from the head slot and count, so they change only after clock edges.

## Structure
- Package fetch_pkg holds:
  - pc_src_t enum: PC_SEQ = 0, PC_JALR = 1, PC_BRANCH = 2, PC_JAL = 3.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_entry_t struct: {ir[31:0], pc[XLEN-1:0]}.
- Sub-module fetch_fifo (parameters DEPTH and entry type): circular buffer with head/tail pointers, push, pop, synchronous flush, count output.
- Top-level logic: PC register, redirect mux, credit check, in-flight tracking.

## Test plan
- Reset release, READY = 1, memory word k = 32'h1000_0000 + k → VALID first at cycle 2 with IR 32'h1000_0000, PC 0, PC_4 4. Then one instruction per cycle, PCs 0, 4, 8, ….
- READY = 0 for 10 cycles after reset with DEPTH = 4 → count saturates at 4 and MEM_RDEN1 stays 0 once full. After READY = 1, instructions arrive in order with no gap or duplicate.
- Redirect PC_SOURCE = 3, MUX_JAL = 32'h0000_0100 while the queue holds 3 entries and a read is in flight → VALID = 0 next cycle, MEM_ADDR1 = 14'h040 one cycle later, first IR from 0x100 three cycles after the redirect.
- Redirect PC_SOURCE = 2 on the same cycle as a pop and a pending push → no stale entry ever appears; next valid PC = MUX_BRANCH.
- RESET asserted mid-stream with 2 entries queued → VALID = 0, IR = NOP, PC = 0 next cycle. Fetch restarts from RESET_PC.
- Wrap-around: redirect to 32'hFFFF_FFFC → PCs FFFF_FFFC then 0000_0000; IF_ID_PC_4 = 0 for the first of these.

Source files
------------

// File: rtl/fetch_pkg.sv
// Package: fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   pc_src_t      - PC_SOURCE encoding (sequential or redirect source)
//   NOP_INSTR     - instruction presented when the IF/ID boundary is empty
//   fetch_entry_t - one queued {ir, pc} pair at the default 32-bit datapath
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JALR   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JAL    = 2'd3
    } pc_src_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]           ir;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Module: fetch_fifo
// Circular buffer of fetched entries with head/tail pointers.
//   CLOCK     - clock, all updates on posedge
//   flush     - synchronous clear; overrides push and pop
//   push      - write push_data at the tail
//   push_data - entry to write
//   pop       - retire the head entry
//   head_data - entry at the head (meaningful only when count != 0)
//   count     - occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             CLOCK,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head_data,
    output logic [CNT_W-1:0] count
);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge CLOCK) begin
        if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // entry storage; contents are never read while count is zero, so no reset
    always_ff @(posedge CLOCK) begin
        if (!flush && push) begin
            mem_r[tail_r] <= push_data;
        end
    end

    assign head_data = mem_r[head_r];
    assign count     = count_r;

    fetch_fifo_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .CLOCK (CLOCK),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

// File: rtl/fetch_fifo_checker.sv
// Module: fetch_fifo_checker
// Property checks for fetch_fifo. The fetch stage reserves a slot before
// issuing a read, so a push into a full queue or a pop from an empty one
// indicates a broken credit scheme.
//   CLOCK  - clock
//   flush  - synchronous clear (checks are suspended in that cycle)
//   push   - write strobe
//   pop    - read strobe
//   count  - current occupancy
module fetch_fifo_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic             CLOCK,
    input logic             flush,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);

    // push must always land in a reserved free slot
    no_overflow_a: assert property (@(posedge CLOCK) disable iff (flush)
        push |-> (count < CNT_W'(DEPTH)));

    // decode only pops a valid head entry
    no_underflow_a: assert property (@(posedge CLOCK) disable iff (flush)
        pop |-> (count != CNT_W'(0)));

endmodule

// File: rtl/fetch_queue_stage.sv
// Module: fetch_queue_stage
// Instruction-fetch stage: PC register, one-cycle-latency reads from memory
// port 1, and a DEPTH-entry queue feeding IF/ID with valid/ready.
//   CLOCK, RESET                   - clock; synchronous active-high reset
//   PC_SOURCE                      - 0 sequential, nonzero = redirect
//   MUX_JALR, MUX_BRANCH, MUX_JAL  - redirect targets
//   MEM_ADDR1, MEM_RDEN1           - read request (word address, strobe)
//   MEM_DOUT1                      - read data, the cycle after MEM_RDEN1
//   IF_ID_READY                    - decode accepts the head entry
//   IF_ID_VALID, IF_ID_IR, IF_ID_PC, IF_ID_PC_4 - head entry (NOP/0 when empty)
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      ADDR_W   = 14,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [1:0]        PC_SOURCE,
    input  logic [XLEN-1:0]   MUX_JALR,
    input  logic [XLEN-1:0]   MUX_BRANCH,
    input  logic [XLEN-1:0]   MUX_JAL,
    output logic [ADDR_W-1:0] MEM_ADDR1,
    output logic              MEM_RDEN1,
    input  logic [31:0]       MEM_DOUT1,
    input  logic              IF_ID_READY,
    output logic              IF_ID_VALID,
    output logic [31:0]       IF_ID_IR,
    output logic [XLEN-1:0]   IF_ID_PC,
    output logic [XLEN-1:0]   IF_ID_PC_4
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned      OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

    // same layout as fetch_entry_t, but sized by this instance's XLEN
    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0]  pc_r;
    logic             inflight_r;
    logic [XLEN-1:0]  inflight_pc_r;

    logic             redirect_s;
    logic [XLEN-1:0]  target_s;
    logic             valid_s;
    logic             pop_s;
    logic [OCC_W-1:0] occ_s;
    logic             issue_s;
    logic             push_s;
    logic             flush_s;
    entry_t           push_entry_s;
    entry_t           head_s;
    logic [CNT_W-1:0] count_s;

    // redirect target select
    always_comb begin
        target_s = pc_r;
        case (pc_src_t'(PC_SOURCE))
            PC_JALR:   target_s = MUX_JALR;
            PC_BRANCH: target_s = MUX_BRANCH;
            PC_JAL:    target_s = MUX_JAL;
            default:   target_s = pc_r;
        endcase
    end

    assign redirect_s = (PC_SOURCE != 2'd0);
    assign valid_s    = (count_s != CNT_W'(0));
    assign pop_s      = valid_s & IF_ID_READY;

    // Slots already claimed after this cycle: queued + in flight - leaving.
    // A read may only issue if it still has a free slot to land in, which
    // is what guarantees the queue cannot overflow.
    assign occ_s   = OCC_W'(count_s) + OCC_W'(inflight_r) - OCC_W'(pop_s);
    assign issue_s = !RESET && !redirect_s && (occ_s < DEPTH_OCC);

    // returning data is dropped whenever the queue is being flushed
    assign flush_s = RESET | redirect_s;
    assign push_s  = inflight_r & !flush_s;

    assign push_entry_s.ir = MEM_DOUT1;
    assign push_entry_s.pc = inflight_pc_r;

    // PC register and in-flight read tracking; reset behaves as a redirect
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (redirect_s) begin
            pc_r       <= target_s;
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            pc_r          <= pc_r + PC_STEP;
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLOCK     (CLOCK),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    assign MEM_RDEN1 = issue_s;
    assign MEM_ADDR1 = pc_r[ADDR_W+1:2];

    assign IF_ID_VALID = valid_s;
    assign IF_ID_IR    = valid_s ? head_s.ir : NOP_INSTR;
    assign IF_ID_PC    = valid_s ? head_s.pc : '0;
    assign IF_ID_PC_4  = valid_s ? (head_s.pc + PC_STEP) : '0;

endmodule
